// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter that merges NUM_REQ write requesters onto
// one FIFO write port. Multi-beat packets (req_last=0 on the first beat) hold
// the grant until the beat carrying req_last=1 has been written.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   req_valid/last/data per-requester handshake (data packed i*DATA_W +: DATA_W)
//   req_ready           per-requester accept, one-hot or zero, combinational
//   i_wren, i_wrdata    registered FIFO write strobe and data
//   o_full, o_alm_full  FIFO status (no free entry / exactly one free entry)
//   grant_id            registered index of the current/last granted requester
//   locked              high while a multi-beat packet owns the grant
//
// state | meaning
// ARB   | round-robin search from rr_ptr, any requester may win
// LOCK  | packet in progress, only lock_id is served
module fifo_wr_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      i_wren,
  output logic [DATA_W-1:0]         i_wrdata,
  input  logic                      o_full,
  input  logic                      o_alm_full,
  output logic [ID_W-1:0]           grant_id,
  output logic                      locked
);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_lock_id;
  logic [ID_W-1:0]     r_grant_id;
  logic                r_wren;
  logic [DATA_W-1:0]   r_wrdata;

  logic                w_can_wr;
  logic                w_any_valid;
  logic [ID_W-1:0]     w_winner;
  logic [ID_W-1:0]     w_sel_id;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_xfer;
  logic [ID_W-1:0]     w_next_ptr;
  logic [NUM_REQ-1:0]  w_req_ready;

  // The write registered last cycle consumes the single free entry when
  // almost full, so it must be counted against the FIFO here. Reset also
  // blocks every handshake.
  assign w_can_wr = !rst && !o_full && !(o_alm_full && r_wren);

  // Round-robin search: scanning from the farthest offset down to zero lets
  // the closest valid requester to rr_ptr overwrite any earlier hit.
  always_comb begin
    w_any_valid = 1'b0;
    w_winner    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_any_valid = 1'b1;
        w_winner    = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_sel_id    = w_winner;
    w_sel_valid = w_any_valid;
    if (r_state == ST_LOCK) begin
      w_sel_id    = r_lock_id;
      w_sel_valid = req_valid[r_lock_id];
    end
    w_xfer     = w_sel_valid && w_can_wr;
    w_sel_last = req_last[w_sel_id];
    w_sel_data = req_data[int'(w_sel_id)*DATA_W +: DATA_W];
    w_req_ready[w_sel_id] = w_xfer;
    w_next_ptr = (w_sel_id == ID_W'(NUM_REQ - 1)) ? '0 : w_sel_id + 1'b1;
    case (r_state)
      ST_ARB:  if (w_xfer && !w_sel_last) w_state_nxt = ST_LOCK;
      ST_LOCK: if (w_xfer &&  w_sel_last) w_state_nxt = ST_ARB;
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ARB;
      r_rr_ptr   <= '0;
      r_lock_id  <= '0;
      r_grant_id <= '0;
      r_wren     <= 1'b0;
      r_wrdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wren  <= w_xfer;
      if (w_xfer) begin
        r_wrdata   <= w_sel_data;
        r_grant_id <= w_sel_id;
        if (w_sel_last) begin
          r_rr_ptr <= w_next_ptr;
        end else if (r_state == ST_ARB) begin
          r_lock_id <= w_sel_id;
        end
      end
    end
  end

  assign req_ready = w_req_ready;
  assign i_wren    = r_wren;
  assign i_wrdata  = r_wrdata;
  assign grant_id  = r_grant_id;
  assign locked    = (r_state == ST_LOCK);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Testbench for fifo_wr_arb: directed vector table followed by randomized
// cycles checked against a packet-level reference model.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            i_wren;
  logic [DW-1:0]   i_wrdata;
  logic            o_full;
  logic            o_alm_full;
  logic [1:0]      grant_id;
  logic            locked;

  fifo_wr_arb #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .i_wren(i_wren), .i_wrdata(i_wrdata),
    .o_full(o_full), .o_alm_full(o_alm_full),
    .grant_id(grant_id), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        full;
    logic        alm;
    logic [3:0]  e_ready;
    logic        e_wren;
    logic [7:0]  e_data;
    logic        e_locked;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  // Reference model: which requester owns an open packet (-1 = none), where
  // the next round-robin search starts, and what the write port shows.
  int       m_owner = -1;
  int       m_rr    = 0;
  bit       m_wren  = 1'b0;
  bit [7:0] m_data  = '0;
  int       m_gid   = 0;
  bit [3:0] m_ready;
  logic [3:0] s_ready;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d, input logic f, input logic a,
                              input logic [3:0] er, input logic ew, input logic [7:0] ed,
                              input logic el, input logic [1:0] eg);
    vec_t x;
    x.rst = r; x.v = v; x.l = l; x.d = d; x.full = f; x.alm = a;
    x.e_ready = er; x.e_wren = ew; x.e_data = ed; x.e_locked = el; x.e_gid = eg;
    tbl.push_back(x);
  endfunction

  // Drive one cycle of inputs, sample req_ready before the edge, advance the
  // model across the edge, leave outputs settled 1ns after the edge.
  task automatic apply(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic f, input logic a);
    int  w;
    bit  can;
    rst = r; req_valid = v; req_last = l; req_data = d; o_full = f; o_alm_full = a;
    #1;
    s_ready = req_ready;
    can = !r && !f && !(a && m_wren);
    w = -1;
    if (m_owner >= 0) begin
      if (v[m_owner]) w = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && v[(m_rr + k) % N]) w = (m_rr + k) % N;
      end
    end
    m_ready = (w >= 0 && can) ? 4'(1 << w) : 4'h0;
    @(posedge clk);
    #1;
    if (r) begin
      m_owner = -1; m_rr = 0; m_wren = 0; m_data = '0; m_gid = 0;
    end else begin
      m_wren = (m_ready != 0);
      if (m_wren) begin
        m_data = d[w*8 +: 8];
        m_gid  = w;
        if (l[w]) begin
          m_owner = -1;
          m_rr    = (w + 1) % N;
        end else begin
          m_owner = w;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    o_full = 1'b0; o_alm_full = 1'b0;

    //   rst  v      l      data          fu al  ready  wren data  lck gid
    // single requester, two single-beat writes
    add(1, 4'h0, 4'h0, 32'h0,         0, 0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'h1, 4'h1, 32'h000000A1,  0, 0, 4'h1, 1, 8'hA1, 0, 0);
    add(0, 4'h1, 4'h1, 32'h000000A2,  0, 0, 4'h1, 1, 8'hA2, 0, 0);
    add(0, 4'h0, 4'h0, 32'h0,         0, 0, 4'h0, 0, 8'hA2, 0, 0);
    // all four streaming single beats: round-robin with wrap
    add(1, 4'hF, 4'hF, 32'h13121110,  0, 0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'hF, 4'hF, 32'h13121110,  0, 0, 4'h1, 1, 8'h10, 0, 0);
    add(0, 4'hF, 4'hF, 32'h13121110,  0, 0, 4'h2, 1, 8'h11, 0, 1);
    add(0, 4'hF, 4'hF, 32'h13121110,  0, 0, 4'h4, 1, 8'h12, 0, 2);
    add(0, 4'hF, 4'hF, 32'h13121110,  0, 0, 4'h8, 1, 8'h13, 0, 3);
    add(0, 4'hF, 4'hF, 32'h13121110,  0, 0, 4'h1, 1, 8'h10, 0, 0);
    add(0, 4'hF, 4'hF, 32'h13121110,  0, 0, 4'h2, 1, 8'h11, 0, 1);
    // req1 three-beat packet while req2 waits
    add(1, 4'h0, 4'h0, 32'h0,         0, 0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'h6, 4'h4, 32'h00C0B100,  0, 0, 4'h2, 1, 8'hB1, 1, 1);
    add(0, 4'h6, 4'h4, 32'h00C0B200,  0, 0, 4'h2, 1, 8'hB2, 1, 1);
    add(0, 4'h6, 4'h6, 32'h00C0B300,  0, 0, 4'h2, 1, 8'hB3, 0, 1);
    add(0, 4'h4, 4'h4, 32'h00C00000,  0, 0, 4'h4, 1, 8'hC0, 0, 2);
    // almost-full / full throttling
    add(0, 4'h1, 4'h1, 32'h000000D1,  0, 1, 4'h0, 0, 8'hC0, 0, 2);
    add(0, 4'h1, 4'h1, 32'h000000D1,  0, 1, 4'h1, 1, 8'hD1, 0, 0);
    add(0, 4'h1, 4'h1, 32'h000000D2,  0, 1, 4'h0, 0, 8'hD1, 0, 0);
    add(0, 4'h1, 4'h1, 32'h000000D2,  1, 0, 4'h0, 0, 8'hD1, 0, 0);
    add(0, 4'h1, 4'h1, 32'h000000D2,  1, 0, 4'h0, 0, 8'hD1, 0, 0);
    add(0, 4'hF, 4'hF, 32'h000000D2,  1, 0, 4'h0, 0, 8'hD1, 0, 0);
    // reset in the middle of a req3 packet
    add(0, 4'h8, 4'h0, 32'hE1000000,  0, 0, 4'h8, 1, 8'hE1, 1, 3);
    add(0, 4'h9, 4'h0, 32'hE20000F0,  0, 0, 4'h8, 1, 8'hE2, 1, 3);
    add(1, 4'h9, 4'h0, 32'hE20000F0,  0, 0, 4'h0, 0, 8'h00, 0, 0);
    add(0, 4'h9, 4'h9, 32'hE30000F1,  0, 0, 4'h1, 1, 8'hF1, 0, 0);
    add(0, 4'h0, 4'h0, 32'h0,         0, 0, 4'h0, 0, 8'hF1, 0, 0);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].full, tbl[i].alm);
      chk($sformatf("vec%0d ready", i), int'(s_ready),  int'(tbl[i].e_ready));
      chk($sformatf("vec%0d wren", i),  int'(i_wren),   int'(tbl[i].e_wren));
      chk($sformatf("vec%0d data", i),  int'(i_wrdata), int'(tbl[i].e_data));
      chk($sformatf("vec%0d locked", i), int'(locked),  int'(tbl[i].e_locked));
      chk($sformatf("vec%0d gid", i),   int'(grant_id), int'(tbl[i].e_gid));
    end

    for (int c = 0; c < 600; c++) begin
      logic [3:0]  rv, rl;
      logic [31:0] rd;
      logic        rf, ra, rr;
      rv = 4'($urandom_range(0, 15));
      rl = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      rd = $urandom;
      rf = ($urandom_range(0, 9) == 0);
      ra = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 63) == 0);
      apply(rr, rv, rl, rd, rf, ra);
      chk("rnd ready",  int'(s_ready),  int'(m_ready));
      chk("rnd wren",   int'(i_wren),   int'(m_wren));
      chk("rnd data",   int'(i_wrdata), int'(m_data));
      chk("rnd locked", int'(locked),   int'(m_owner >= 0));
      chk("rnd gid",    int'(grant_id), m_gid);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
